// File: rtl/pe_op_sequencer.sv
// Vector-op control sequencer for the processing element: accepts one command, steps through
// its element beats against an operand handshake, and drives the PE mux selects and enables.
module pe_op_sequencer #(
    parameter int unsigned VL_W    = 5,
    parameter int unsigned NUM_OPS = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [VL_W-1:0] cmd_vl,
    input  logic            opnd_valid,
    output logic            opnd_ready,
    output logic [VL_W-1:0] elem_idx,
    output logic [1:0]      mux_add_a,
    output logic [1:0]      mux_add_b,
    output logic            mux_c_acc,
    output logic [1:0]      mux_sat8,
    output logic            mux_relu,
    output logic [1:0]      mux_res,
    output logic            mux_comb,
    output logic            enable_acc,
    output logic            wb_valid,
    output logic [VL_W-1:0] wb_idx,
    output logic            done,
    output logic            err_illegal
);

    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpMul  = 3'd1;
    localparam logic [2:0] OpMacc = 3'd2;
    localparam logic [2:0] OpDot  = 3'd3;
    localparam logic [2:0] OpRelu = 3'd4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [2:0]      r_op;
    logic [VL_W-1:0] r_vl;
    logic [VL_W-1:0] r_idx;
    logic            r_done;
    logic            r_err;

    logic            w_accept;
    logic            w_illegal;
    logic            w_vl_zero;
    logic            w_beat;
    logic            w_last;
    logic            w_is_dot;

    assign w_accept  = (r_state == StIdle) && cmd_valid;
    assign w_illegal = (32'(cmd_op) >= NUM_OPS);
    assign w_vl_zero = (cmd_vl == '0);
    assign w_beat    = (r_state == StRun) && opnd_valid;
    // vl is nonzero whenever RUN is entered, so vl-1 never underflows here
    assign w_last    = (r_idx == (r_vl - VL_W'(1)));
    assign w_is_dot  = (r_op == OpDot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept && !w_illegal && !w_vl_zero) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (w_beat && w_last) begin
                    w_state_next = w_is_dot ? StDrain : StIdle;
                end
            end
            StDrain: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_vl   <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_vl   <= cmd_vl;
                r_idx  <= '0;
                r_err  <= w_illegal;
                r_done <= !w_illegal && w_vl_zero;
            end else if (w_beat) begin
                r_idx  <= r_idx + VL_W'(1);
                r_done <= w_last && !w_is_dot;
            end else if (r_state == StDrain) begin
                r_done <= 1'b1;
            end
        end
    end

    always_comb begin
        cmd_ready   = (r_state == StIdle) && !rst;
        opnd_ready  = 1'b0;
        elem_idx    = '0;
        mux_add_a   = 2'd0;
        mux_add_b   = 2'd0;
        mux_c_acc   = 1'b0;
        mux_sat8    = 2'd0;
        mux_relu    = 1'b0;
        mux_res     = 2'd0;
        mux_comb    = 1'b0;
        enable_acc  = 1'b0;
        wb_valid    = 1'b0;
        wb_idx      = '0;
        done        = r_done;
        err_illegal = r_err;

        // Selects stay at the op's values through stalled RUN cycles and DRAIN
        if (r_state != StIdle) begin
            case (r_op)
                OpAdd: begin
                    mux_c_acc = 1'b1;
                    mux_sat8  = 2'd1;
                    mux_res   = 2'd2;
                    mux_comb  = 1'b1;
                end
                OpMul: begin
                    mux_add_a = 2'd1;
                    mux_c_acc = 1'b1;
                    mux_sat8  = 2'd2;
                    mux_res   = 2'd2;
                    mux_comb  = 1'b1;
                end
                OpMacc: begin
                    mux_add_a = 2'd1;
                    mux_add_b = 2'd1;
                    mux_c_acc = 1'b1;
                    mux_sat8  = 2'd1;
                    mux_res   = 2'd2;
                    mux_comb  = 1'b1;
                end
                OpDot: begin
                    mux_add_a = 2'd1;
                    mux_add_b = 2'd1;
                    mux_c_acc = (r_idx == '0);
                    mux_sat8  = 2'd1;
                    mux_res   = 2'd1;
                end
                OpRelu: begin
                    mux_c_acc = 1'b1;
                    mux_res   = 2'd3;
                    mux_comb  = 1'b1;
                end
                default: ;
            endcase
        end

        case (r_state)
            StRun: begin
                if (opnd_valid) begin
                    opnd_ready = 1'b1;
                    elem_idx   = r_idx;
                    if (w_is_dot) begin
                        enable_acc = 1'b1;
                    end else begin
                        wb_valid = 1'b1;
                        wb_idx   = r_idx;
                    end
                end
            end
            StDrain: begin
                mux_comb = 1'b0;
                wb_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pe_op_sequencer.sv
// Directed, table-driven bench for pe_op_sequencer: per-cycle input/expected-output records
// plus a bounded max-length command sequence.
module tb_pe_op_sequencer;

    localparam int unsigned VL_W = 5;

    // {add_a, add_b, c_acc, sat8, relu, res, comb}
    localparam logic [10:0] SEL_Z    = 11'b00_00_0_00_0_00_0;
    localparam logic [10:0] SEL_ADD  = 11'b00_00_1_01_0_10_1;
    localparam logic [10:0] SEL_MUL  = 11'b01_00_1_10_0_10_1;
    localparam logic [10:0] SEL_MACC = 11'b01_01_1_01_0_10_1;
    localparam logic [10:0] SEL_RELU = 11'b00_00_1_00_0_11_1;
    localparam logic [10:0] SEL_DOT0 = 11'b01_01_1_01_0_01_0;
    localparam logic [10:0] SEL_DOTN = 11'b01_01_0_01_0_01_0;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_op;
    logic [VL_W-1:0] cmd_vl;
    logic            opnd_valid;
    logic            opnd_ready;
    logic [VL_W-1:0] elem_idx;
    logic [1:0]      mux_add_a;
    logic [1:0]      mux_add_b;
    logic            mux_c_acc;
    logic [1:0]      mux_sat8;
    logic            mux_relu;
    logic [1:0]      mux_res;
    logic            mux_comb;
    logic            enable_acc;
    logic            wb_valid;
    logic [VL_W-1:0] wb_idx;
    logic            done;
    logic            err_illegal;

    always #5 clk = ~clk;

    pe_op_sequencer #(
        .VL_W    (VL_W),
        .NUM_OPS (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_vl      (cmd_vl),
        .opnd_valid  (opnd_valid),
        .opnd_ready  (opnd_ready),
        .elem_idx    (elem_idx),
        .mux_add_a   (mux_add_a),
        .mux_add_b   (mux_add_b),
        .mux_c_acc   (mux_c_acc),
        .mux_sat8    (mux_sat8),
        .mux_relu    (mux_relu),
        .mux_res     (mux_res),
        .mux_comb    (mux_comb),
        .enable_acc  (enable_acc),
        .wb_valid    (wb_valid),
        .wb_idx      (wb_idx),
        .done        (done),
        .err_illegal (err_illegal)
    );

    typedef struct packed {
        logic            rst;
        logic            cv;
        logic [2:0]      op;
        logic [VL_W-1:0] vl;
        logic            ov;
        logic            crdy;
        logic            ordy;
        logic [VL_W-1:0] eidx;
        logic [10:0]     sel;
        logic            ena;
        logic            wbv;
        logic [VL_W-1:0] wbi;
        logic            dn;
        logic            er;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic cv, input int op, input int vl,
                                input logic ov, input logic crdy, input logic ordy,
                                input int eidx, input logic [10:0] sel, input logic ena,
                                input logic wbv, input int wbi, input logic dn,
                                input logic er);
        vec_t v;
        v.rst = r;       v.cv = cv;       v.op = 3'(op);   v.vl = VL_W'(vl);  v.ov = ov;
        v.crdy = crdy;   v.ordy = ordy;   v.eidx = VL_W'(eidx);  v.sel = sel;
        v.ena = ena;     v.wbv = wbv;     v.wbi = VL_W'(wbi);    v.dn = dn;  v.er = er;
        return v;
    endfunction

    function automatic logic [26:0] outs();
        return {cmd_ready, opnd_ready, elem_idx, mux_add_a, mux_add_b, mux_c_acc, mux_sat8,
                mux_relu, mux_res, mux_comb, enable_acc, wb_valid, wb_idx, done, err_illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int i);
        logic [26:0] exp;
        @(negedge clk);
        rst        = v.rst;
        cmd_valid  = v.cv;
        cmd_op     = v.op;
        cmd_vl     = v.vl;
        opnd_valid = v.ov;
        #2;
        exp = {v.crdy, v.ordy, v.eidx, v.sel, v.ena, v.wbv, v.wbi, v.dn, v.er};
        check($sformatf("vec%0d", i), 32'(outs()), 32'(exp));
    endtask

    initial begin
        int beats;
        int last_idx;
        bit got_done;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_vl = '0; opnd_valid = 1'b0;

        //                  r cv op vl ov  crdy ordy eidx sel ena wbv wbi dn er
        vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 4, 1,  0, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        // MUL vl=4, operands always present
        vecs.push_back(mk(0, 1, 1, 4, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, SEL_MUL,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 1, SEL_MUL,  0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 2, SEL_MUL,  0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 3, SEL_MUL,  0, 1, 3, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        // DOT vl=3, operand pattern 1,0,1,1, then DRAIN ignoring opnd_valid
        vecs.push_back(mk(0, 1, 3, 3, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, SEL_DOT0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  0, 0, 0, SEL_DOTN, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 1, SEL_DOTN, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 2, SEL_DOTN, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 0, 0, SEL_DOTN, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 1, 0));
        // Illegal opcodes 6 and 5 (first value past the legal range)
        vecs.push_back(mk(0, 1, 6, 2, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 5, 1, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        // ADD vl=0
        vecs.push_back(mk(0, 1, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        // RELU vl=2 with cmd_valid held during RUN
        vecs.push_back(mk(0, 1, 4, 2, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 1,  0, 1, 0, SEL_RELU, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 0,  0, 0, 0, SEL_RELU, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 5, 1,  0, 1, 1, SEL_RELU, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 1, 0));
        // MACC vl=1, then ADD vl=1 accepted in the done cycle
        vecs.push_back(mk(0, 1, 2, 1, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, SEL_MACC, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, SEL_ADD,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 1, 0));
        // DOT vl=5 abandoned by reset on beat 2, then a normal MUL vl=1
        vecs.push_back(mk(0, 1, 3, 5, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, SEL_DOT0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 1, SEL_DOTN, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1,  0, 1, 0, SEL_MUL,  0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0,  1, 0, 0, SEL_Z,    0, 0, 0, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Maximum vector length: 31 beats, last index 30, bounded wait for done
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_vl = 5'd31; opnd_valid = 1'b1;
        beats = 0; last_idx = -1; got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            #2;
            if (wb_valid) begin
                beats++;
                last_idx = int'(wb_idx);
            end
            if (done) got_done = 1'b1;
        end
        opnd_valid = 1'b0;
        check("maxvl_done_seen", 32'(got_done), 32'd1);
        check("maxvl_beats", 32'(beats), 32'd31);
        check("maxvl_last_idx", 32'(last_idx), 32'd30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_op_sequencer.md
Name: pe_op_sequencer

Overview:
- Control stage directly upstream of the processing element.
- Accepts one vector-op command, then steps through its vl element beats, driving the PE datapath mux selects and enable_acc each beat.
- Paces beats against an operand-valid handshake and flags PE result writeback (r) with an element index.
- For the dot-product reduction, it sequences accumulation in the PE acc_reg and then emits a single drain/writeback beat.

Parameters:
- VL_W, 5, width of the vector-length field; max vl = 2^VL_W-1.
- NUM_OPS, 5, number of supported opcodes (0..NUM_OPS-1); others are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer idle, can accept a command.
- cmd_op  in  3  0=ADD 1=MUL 2=MACC 3=DOT 4=RELU.
- cmd_vl  in  VL_W  element count.
- opnd_valid  in  1  a/b/c operands for the current beat are present at the PE.
- opnd_ready  out  1  current beat is consumed this cycle.
- elem_idx  out  VL_W  index of the element being issued.
- mux_add_a  out  2  PE adder A select.
- mux_add_b  out  2  PE adder B select.
- mux_c_acc  out  1  PE c/accumulator select.
- mux_sat8  out  2  PE sat8 input select.
- mux_relu  out  1  PE relu input select.
- mux_res  out  2  PE result select.
- mux_comb  out  1  PE writeback select.
- enable_acc  out  1  PE accumulator write enable.
- wb_valid  out  1  PE r is a valid result this cycle.
- wb_idx  out  VL_W  destination element index for r.
- done  out  1  one-cycle pulse on command completion.
- err_illegal  out  1  one-cycle pulse when an illegal opcode is dropped.

Behaviour:
- States: IDLE, RUN, DRAIN. Registered: state, op, vl, idx (VL_W). All other outputs are combinational decodes of these registers and opnd_valid.
- Reset (async, while rst=1): state=IDLE, op=0, vl=0, idx=0. All control outputs =0, wb_valid=0, opnd_ready=0, done=0, err_illegal=0, cmd_ready=1 once rst deasserts. Reset mid-command abandons it with no done pulse.
- IDLE:
  - cmd_ready=1. Accept on cmd_valid&cmd_ready: latch op, vl; idx=0.
  - Illegal op: stay IDLE, pulse err_illegal next cycle.
  - vl=0: stay IDLE, pulse done next cycle.
  - Otherwise go to RUN.
- RUN:
  - cmd_ready=0. A beat fires when opnd_valid=1; then opnd_ready=1 and elem_idx=idx.
  - No beat (opnd_valid=0): all enables and wb_valid held at 0; selects hold the op's values.
  - Per-op decode (add_a, add_b, c_acc, sat8, relu, res, comb):
    - ADD: 0,0,1,1,0,2,1.
    - MUL: 1,0,1,2,0,2,1.
    - MACC: 1,1,1,1,0,2,1.
    - RELU: 0,0,1,0,0,3,1.
    - DOT: 1,1,(idx==0),1,0,1,0.
  - Element-wise ops (ADD/MUL/MACC/RELU): on a beat, wb_valid=1 and wb_idx=idx in the same cycle (combinational PE path); enable_acc=0.
  - DOT: on a beat, enable_acc=1 and wb_valid=0. Beat 0 seeds from c (c_acc=1); later beats add to acc_reg (c_acc=0); acc saturates at 12 bits in the PE.
  - idx increments per beat. On the beat with idx==vl-1: element-wise ops go to IDLE and pulse done next cycle; DOT goes to DRAIN.
- DRAIN (DOT only, exactly 1 cycle):
  - Selects as DOT, comb=0, enable_acc=0, wb_valid=1, wb_idx=0; r = acc_reg[7:0].
  - Next cycle: IDLE with done=1.
  - Does not wait on opnd_valid; opnd_ready=0.
- Back-to-back commands: cmd_ready returns in the cycle done pulses; minimum one idle cycle between commands.
- idx never wraps: vl ≤ 2^VL_W-1 and the last beat is vl-1.

Test Plan:
- MUL vl=4, opnd_valid held high -> 4 consecutive cycles of wb_valid with wb_idx 0,1,2,3, mux_res=2, mux_sat8=2; done one cycle after idx 3.
- DOT vl=3, opnd_valid pattern 1,0,1,1 -> enable_acc on 3 beats, mux_c_acc=1 only on the first; DRAIN cycle with wb_valid=1, mux_comb=0; done next cycle; 6 cycles from accept to done.
- cmd_op=6 -> no RUN, err_illegal pulses once, cmd_ready stays 1.
- ADD vl=0 -> no beats, done pulses 1 cycle after accept.
- rst asserted during DOT beat 2 of 5 -> outputs zero immediately, no done; next command is accepted normally.
- RELU vl=2 -> mux_relu=0, mux_res=3, mux_comb=1; wb_valid on both beats; cmd_valid held high during RUN is ignored (cmd_ready=0).
